ps2_key_tracker: RTL and testbench
==================================

# ps2_key_tracker

Scan-code parser and held-key tracker sitting between the PS/2 byte decoder and the key-to-note mapper. It consumes raw bytes (Set 2 make/break/extended sequences), emits one-cycle press/release events, and keeps a last-pressed-priority stack of held keys. The note path always sees the newest still-held key, or 0 when no key is held. This gives monophonic "last note wins" playing with correct fallback to the previous key on release.

## Interface
- `DEPTH`, 4: held-key stack entries (2..8).
- `TIMEOUT`, 200000: sys_clk cycles a partial prefix sequence may wait for its next byte (2 ms at 100 MHz).
- `sys_clk` in 1: system clock; all logic on the rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `data_in` in 8: byte from the PS/2 decoder.
- `data_valid` in 1: one-cycle strobe; `data_in` is valid this cycle.
- `overflow` in 1: decoder FIFO overflow; level or pulse.
- `key_code` out 8: code of the last event.
- `key_ext` out 1: last event was E0-extended.
- `key_press` out 1: one-cycle pulse on a new (non-repeat) make.
- `key_release` out 1: one-cycle pulse on a break.
- `held_code` out 8: code at stack top; 0 when the stack is empty.
- `held_ext` out 1: ext flag of the stack top; 0 when empty.
- `held_count` out 4: number of valid stack entries.

## Operation
- Parser FSM states: IDLE, EXT (E0 seen), BRK (F0 seen), EXT_BRK (E0 then F0 seen).
- IDLE:
  - E0 → EXT.
  - F0 → BRK.
  - Bytes 00, AA, EE, FA, FE and FF are ignored.
  - Any other byte is a make with ext=0.
- EXT:
  - F0 → EXT_BRK.
  - E0 stays in EXT.
  - Any other byte is a make with ext=1, then → IDLE.
- BRK: any byte other than E0/F0 is a break with ext=0, then → IDLE. E0/F0 → IDLE with no event.
- EXT_BRK: any byte other than E0/F0 is a break with ext=1, then → IDLE. E0/F0 → IDLE with no event.
- Entry identity is the pair {ext, code}.
- Make of a key already in the stack (typematic repeat): no event, stack unchanged.
- Make of a new key:
  - Push it on top and pulse `key_press`.
  - If the stack is full, drop the oldest (bottom) entry first.
- Break:
  - Always pulse `key_release` with that code and ext.
  - If the entry is present, remove it and compact the entries above it downward, preserving order.
  - If the entry is absent, the stack is unchanged.
- Timeout: in any non-IDLE state the counter counts every cycle and is cleared when a byte is accepted. When it reaches TIMEOUT−1, return to IDLE with no event.
- Overflow (sampled high on any cycle): FSM → IDLE, stack flushed, counter cleared, no events that cycle. Overflow beats a simultaneous `data_valid`, whose byte is discarded.

## Timing
- Reset values: all outputs 0, FSM in IDLE, stack empty, counter 0.
- Event latency: `key_press`/`key_release` rise exactly 1 cycle after the `data_valid` cycle carrying the final byte, and are high for exactly 1 cycle.
- `key_code` and `key_ext` update in the same cycle as the pulse and then hold until the next event.
- `held_*` outputs are registered and update in the same cycle as the event pulse.
- An overflow flush shows `held_count`=0 on the next cycle.
- Back-to-back `data_valid` on consecutive cycles must be accepted without loss; one byte is processed per cycle.
- Reset asserted mid-sequence: immediate asynchronous return to reset values; the partial sequence is lost.

## Structure
- Shared package `ps2_pkg` holds:
  - constants PS2_EXT=8'hE0 and PS2_BRK=8'hF0;
  - the ignored-code list;
  - the parser state enum;
  - the `key_entry_t` {ext, code} struct.
- Sub-module `key_stack`:
  - DEPTH-entry shift/compact register with ops push, remove and flush;
  - outputs `present`, `full`, `top` and `count`;
  - all ops complete in one cycle.
- The parser FSM and timeout counter live in `ps2_key_tracker`.

## Test plan
- Bytes 1C, F0 1C → `key_press` (code 1C, ext 0) then `key_release`. `held_code` reads 1C between the two and 0 after.
- Make 1C, make 1B, break 1B → `held_code` goes 1C, 1B, 1C. Break 1C → 0, `held_count` 0.
- Make 1C ×5 (typematic) → exactly one `key_press`, `held_count` 1.
- E0 75 then E0 F0 75 → press and release with ext=1. Also, with DEPTH=4, make 15 1D 24 2D 2C → 15 dropped, `held_code`=2C, `held_count`=4.
- F0, then idle for TIMEOUT cycles, then 1C → treated as a make (press), not a break.
- Hold 3 keys, then assert `overflow` together with `data_valid` (F0) → no events, `held_count`=0 next cycle. AA and FA alone → no events.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 Set 2 scan-code parser and held-key stack.
package ps2_pkg;

  localparam logic [7:0] PS2_EXT = 8'hE0;
  localparam logic [7:0] PS2_BRK = 8'hF0;

  // Controller/handshake bytes that never represent a key in the idle state.
  localparam int unsigned PS2_NUM_IGNORED = 6;
  localparam logic [8*PS2_NUM_IGNORED-1:0] PS2_IGNORED_CODES =
    {8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF};

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_EXT     = 2'd1,
    ST_BRK     = 2'd2,
    ST_EXT_BRK = 2'd3
  } parser_state_e;

  typedef struct packed {
    logic       ext;
    logic [7:0] code;
  } key_entry_t;

  function automatic logic is_ignored_code(input logic [7:0] code);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < int'(PS2_NUM_IGNORED); i++) begin
      hit = hit | (PS2_IGNORED_CODES[8*i +: 8] == code);
    end
    return hit;
  endfunction

endpackage

// File: rtl/key_stack.sv
// Last-pressed-priority stack of held keys: index 0 is the oldest entry,
// index count-1 the newest. Push, remove (with compaction) and flush take one cycle.
module key_stack
  import ps2_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic       sys_clk,
  input  logic       rst_n,
  input  logic       push,
  input  logic       remove,
  input  logic       flush,
  input  key_entry_t entry,
  output logic       present,
  output logic       full,
  output key_entry_t top,
  output logic [3:0] count
);

  key_entry_t       entries_r   [DEPTH];
  key_entry_t       entries_n_s [DEPTH];
  logic [3:0]       count_r;
  logic [3:0]       count_n_s;
  key_entry_t       top_r;
  key_entry_t       top_n_s;
  logic [DEPTH-1:0] hit_s;
  logic [DEPTH-1:0] at_or_above_s;

  // Locate the entry among valid slots; at_or_above marks slots that shift down on removal
  always_comb begin
    hit_s         = '0;
    at_or_above_s = '0;
    for (int i = 0; i < DEPTH; i++) begin
      hit_s[i] = (4'(i) < count_r) && (entries_r[i] == entry);
    end
    at_or_above_s[0] = hit_s[0];
    for (int i = 1; i < DEPTH; i++) begin
      at_or_above_s[i] = at_or_above_s[i-1] | hit_s[i];
    end
  end

  assign present = |hit_s;
  assign full    = (count_r == 4'(DEPTH));

  // Next stack contents; flush beats remove beats push
  always_comb begin
    entries_n_s = entries_r;
    count_n_s   = count_r;
    if (flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        entries_n_s[i] = '0;
      end
      count_n_s = 4'd0;
    end else if (remove && present) begin
      for (int i = 0; i < DEPTH - 1; i++) begin
        entries_n_s[i] = at_or_above_s[i] ? entries_r[i+1] : entries_r[i];
      end
      entries_n_s[DEPTH-1] = '0;
      count_n_s            = count_r - 4'd1;
    end else if (push && full) begin
      // Oldest entry falls off the bottom to make room
      for (int i = 0; i < DEPTH - 1; i++) begin
        entries_n_s[i] = entries_r[i+1];
      end
      entries_n_s[DEPTH-1] = entry;
    end else if (push) begin
      for (int i = 0; i < DEPTH; i++) begin
        entries_n_s[i] = (4'(i) == count_r) ? entry : entries_r[i];
      end
      count_n_s = count_r + 4'd1;
    end else begin
      entries_n_s = entries_r;
      count_n_s   = count_r;
    end

    top_n_s = '0;
    for (int i = 0; i < DEPTH; i++) begin
      top_n_s = (count_n_s == 4'(i + 1)) ? entries_n_s[i] : top_n_s;
    end
  end

  // Stack storage plus registered top/count views
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        entries_r[i] <= '0;
      end
      count_r <= 4'd0;
      top_r   <= '0;
    end else begin
      entries_r <= entries_n_s;
      count_r   <= count_n_s;
      top_r     <= top_n_s;
    end
  end

  assign top   = top_r;
  assign count = count_r;

endmodule

// File: rtl/ps2_key_tracker.sv
// Set 2 make/break/extended parser feeding a held-key stack; the stack top
// drives the monophonic note path with last-note-wins priority.
module ps2_key_tracker
  import ps2_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 200000
) (
  input  logic       sys_clk,
  input  logic       rst_n,
  input  logic [7:0] data_in,
  input  logic       data_valid,
  input  logic       overflow,
  output logic [7:0] key_code,
  output logic       key_ext,
  output logic       key_press,
  output logic       key_release,
  output logic [7:0] held_code,
  output logic       held_ext,
  output logic [3:0] held_count
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT - 1);

  parser_state_e state_r;
  parser_state_e state_n_s;
  logic [CW-1:0] tmo_cnt_r;
  logic [CW-1:0] tmo_cnt_n_s;
  logic          make_s;
  logic          brk_s;
  logic          ev_ext_s;
  logic          push_s;
  logic          present_s;
  logic          full_s;
  key_entry_t    ev_entry_s;
  key_entry_t    top_s;
  logic [3:0]    count_s;

  // Parser state and prefix timeout counter
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= ST_IDLE;
      tmo_cnt_r <= '0;
    end else begin
      state_r   <= state_n_s;
      tmo_cnt_r <= tmo_cnt_n_s;
    end
  end

  assign ev_ext_s   = (state_r == ST_EXT) || (state_r == ST_EXT_BRK);
  assign ev_entry_s = '{ext: ev_ext_s, code: data_in};

  // Next-state and make/break decode; overflow discards any byte in the same cycle
  always_comb begin
    state_n_s   = state_r;
    tmo_cnt_n_s = '0;
    make_s      = 1'b0;
    brk_s       = 1'b0;
    if (overflow) begin
      state_n_s = ST_IDLE;
    end else if (data_valid) begin
      case (state_r)
        ST_IDLE: begin
          if (data_in == PS2_EXT) begin
            state_n_s = ST_EXT;
          end else if (data_in == PS2_BRK) begin
            state_n_s = ST_BRK;
          end else if (is_ignored_code(data_in)) begin
            state_n_s = ST_IDLE;
          end else begin
            make_s    = 1'b1;
            state_n_s = ST_IDLE;
          end
        end
        ST_EXT: begin
          if (data_in == PS2_BRK) begin
            state_n_s = ST_EXT_BRK;
          end else if (data_in == PS2_EXT) begin
            state_n_s = ST_EXT;
          end else begin
            make_s    = 1'b1;
            state_n_s = ST_IDLE;
          end
        end
        ST_BRK, ST_EXT_BRK: begin
          if ((data_in == PS2_EXT) || (data_in == PS2_BRK)) begin
            state_n_s = ST_IDLE;
          end else begin
            brk_s     = 1'b1;
            state_n_s = ST_IDLE;
          end
        end
        default: begin
          state_n_s = ST_IDLE;
        end
      endcase
    end else if (state_r != ST_IDLE) begin
      if (tmo_cnt_r == TMO_LAST) begin
        state_n_s = ST_IDLE;
      end else begin
        tmo_cnt_n_s = tmo_cnt_r + CW'(1);
      end
    end else begin
      state_n_s = ST_IDLE;
    end
  end

  // A make of a key already held is a typematic repeat and produces nothing
  assign push_s = make_s & ~present_s & ~full_s | make_s & ~present_s & full_s;

  key_stack #(
    .DEPTH (DEPTH)
  ) u_key_stack (
    .sys_clk (sys_clk),
    .rst_n   (rst_n),
    .push    (push_s),
    .remove  (brk_s),
    .flush   (overflow),
    .entry   (ev_entry_s),
    .present (present_s),
    .full    (full_s),
    .top     (top_s),
    .count   (count_s)
  );

  // Event pulses and last-event code/ext
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      key_press   <= 1'b0;
      key_release <= 1'b0;
      key_code    <= 8'h00;
      key_ext     <= 1'b0;
    end else begin
      key_press   <= push_s;
      key_release <= brk_s;
      if (push_s || brk_s) begin
        key_code <= data_in;
        key_ext  <= ev_ext_s;
      end else begin
        key_code <= key_code;
        key_ext  <= key_ext;
      end
    end
  end

  assign held_code  = top_s.code;
  assign held_ext   = top_s.ext;
  assign held_count = count_s;

endmodule

// File: tb/tb_ps2_key_tracker.sv
// Directed and random bench for ps2_key_tracker against a queue-based model
// of the make/break/prefix rules and the last-pressed-priority key list.
module tb_ps2_key_tracker;

  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 40;

  logic       sys_clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic       data_valid = 1'b0;
  logic       overflow = 1'b0;
  logic [7:0] key_code;
  logic       key_ext;
  logic       key_press;
  logic       key_release;
  logic [7:0] held_code;
  logic       held_ext;
  logic [3:0] held_count;

  ps2_key_tracker #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .sys_clk     (sys_clk),
    .rst_n       (rst_n),
    .data_in     (data_in),
    .data_valid  (data_valid),
    .overflow    (overflow),
    .key_code    (key_code),
    .key_ext     (key_ext),
    .key_press   (key_press),
    .key_release (key_release),
    .held_code   (held_code),
    .held_ext    (held_ext),
    .held_count  (held_count)
  );

  always #5 sys_clk = ~sys_clk;

  int checks = 0;
  int failures = 0;
  int press_seen = 0;

  // Reference model: held keys oldest..newest as {ext, code}, pending prefix flags,
  // and the cycle number of the last accepted byte for the prefix expiry rule.
  logic [8:0] held_q[$];
  bit         pend_e0, pend_f0;
  int         cyc, last_t;
  logic       exp_press, exp_rel, exp_ext;
  logic [7:0] exp_code;

  logic [7:0] pool [12] = '{8'h1C, 8'h1B, 8'h15, 8'h1D, 8'h24, 8'h2D,
                            8'h2C, 8'h75, 8'hE0, 8'hF0, 8'hAA, 8'hFA};

  task automatic check(input string tag, input logic [8:0] obs, input logic [8:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    logic [8:0] top;
    top = (held_q.size() > 0) ? held_q[held_q.size()-1] : 9'h000;
    check("key_press",   {8'h00, key_press},   {8'h00, exp_press});
    check("key_release", {8'h00, key_release}, {8'h00, exp_rel});
    check("key_code",    {1'b0, key_code},     {1'b0, exp_code});
    check("key_ext",     {8'h00, key_ext},     {8'h00, exp_ext});
    check("held_code",   {1'b0, held_code},    {1'b0, top[7:0]});
    check("held_ext",    {8'h00, held_ext},    {8'h00, top[8]});
    check("held_count",  {5'h00, held_count},  9'(held_q.size()));
  endtask

  task automatic model_reset();
    held_q.delete();
    pend_e0 = 1'b0; pend_f0 = 1'b0;
    exp_press = 1'b0; exp_rel = 1'b0; exp_code = 8'h00; exp_ext = 1'b0;
  endtask

  task automatic do_make(input logic e, input logic [7:0] c);
    int idx[$];
    idx = held_q.find_first_index(x) with (x == {e, c});
    if (idx.size() == 0) begin
      if (held_q.size() == DEPTH) void'(held_q.pop_front());
      held_q.push_back({e, c});
      exp_press = 1'b1; exp_code = c; exp_ext = e;
    end
  endtask

  task automatic do_break(input logic e, input logic [7:0] c);
    int idx[$];
    exp_rel = 1'b1; exp_code = c; exp_ext = e;
    idx = held_q.find_first_index(x) with (x == {e, c});
    if (idx.size() != 0) held_q.delete(idx[0]);
  endtask

  task automatic model_step(input logic v, input logic [7:0] b, input logic o);
    cyc++;
    exp_press = 1'b0; exp_rel = 1'b0;
    if (o) begin
      pend_e0 = 1'b0; pend_f0 = 1'b0;
      held_q.delete();
    end else if (v) begin
      // A prefix older than TIMEOUT idle cycles has already been abandoned
      if ((pend_e0 || pend_f0) && (cyc - last_t > TIMEOUT)) begin
        pend_e0 = 1'b0; pend_f0 = 1'b0;
      end
      last_t = cyc;
      if (pend_f0) begin
        if (b != 8'hE0 && b != 8'hF0) do_break(pend_e0, b);
        pend_e0 = 1'b0; pend_f0 = 1'b0;
      end else if (pend_e0) begin
        if (b == 8'hF0) pend_f0 = 1'b1;
        else if (b != 8'hE0) begin
          do_make(1'b1, b);
          pend_e0 = 1'b0;
        end
      end else if (b == 8'hE0) pend_e0 = 1'b1;
      else if (b == 8'hF0) pend_f0 = 1'b1;
      else if (!(b inside {8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF})) do_make(1'b0, b);
    end
  endtask

  task automatic step(input logic v, input logic [7:0] b, input logic o);
    @(negedge sys_clk);
    data_valid = v; data_in = b; overflow = o;
    model_step(v, b, o);
    @(posedge sys_clk);
    #1;
    data_valid = 1'b0; overflow = 1'b0;
    if (key_press === 1'b1) press_seen++;
    check_all();
  endtask

  task automatic send(input logic [7:0] b);
    step(1'b1, b, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0);
  endtask

  initial begin
    cyc = 0; last_t = 0;
    model_reset();
    #12;
    check_all();
    @(negedge sys_clk);
    rst_n = 1'b1;

    // Press and release a single key
    send(8'h1C);
    check("t1_press", {8'h00, key_press}, 9'h001);
    check("t1_held", {1'b0, held_code}, 9'h01C);
    idle(1);
    send(8'hF0); send(8'h1C);
    check("t1_release", {8'h00, key_release}, 9'h001);
    check("t1_empty", {1'b0, held_code}, 9'h000);

    // Fallback to previous key on release
    send(8'h1C); send(8'h1B);
    check("t2_top_1b", {1'b0, held_code}, 9'h01B);
    send(8'hF0); send(8'h1B);
    check("t2_back_1c", {1'b0, held_code}, 9'h01C);
    send(8'hF0); send(8'h1C);
    check("t2_count0", {5'h00, held_count}, 9'h000);

    // Typematic repeat gives exactly one press
    press_seen = 0;
    for (int i = 0; i < 5; i++) begin
      send(8'h1C);
      idle(2);
    end
    check("t3_one_press", 9'(press_seen), 9'd1);
    check("t3_count1", {5'h00, held_count}, 9'h001);
    send(8'hF0); send(8'h1C);

    // Extended keys and eviction of the oldest entry
    send(8'hE0); send(8'h75);
    check("t4_ext_press", {7'h00, key_press, key_ext}, 9'h003);
    send(8'hE0); send(8'hF0); send(8'h75);
    check("t4_ext_rel", {7'h00, key_release, key_ext}, 9'h003);
    send(8'h15); send(8'h1D); send(8'h24); send(8'h2D); send(8'h2C);
    check("t4_top_2c", {1'b0, held_code}, 9'h02C);
    check("t4_count4", {5'h00, held_count}, 9'h004);
    send(8'hF0); send(8'h15);

    // Prefix timeout: just expired vs. arriving on the last cycle
    step(1'b0, 8'h00, 1'b1);
    send(8'hF0); idle(TIMEOUT); send(8'h1C);
    check("t5_timeout_make", {8'h00, key_press}, 9'h001);
    send(8'hF0); idle(TIMEOUT - 1); send(8'h1C);
    check("t5_inwindow_break", {8'h00, key_release}, 9'h001);

    // Overflow beats data_valid and flushes the stack
    send(8'h1C); send(8'h1B); send(8'h15);
    step(1'b1, 8'hF0, 1'b1);
    check("t6_flushed", {5'h00, held_count}, 9'h000);
    send(8'h15);
    send(8'hAA); send(8'hFA);
    check("t6_ignored", {7'h00, key_press, key_release}, 9'h000);

    // Reset in the middle of an extended sequence
    send(8'h24);
    send(8'hE0);
    @(negedge sys_clk);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    @(negedge sys_clk);
    rst_n = 1'b1;
    send(8'h75);
    check("t7_after_rst_ext", {8'h00, key_ext}, 9'h000);

    // Random byte streams with overflows and long gaps
    for (int n = 0; n < 1500; n++) begin
      int r;
      r = int'($urandom_range(0, 99));
      if (r == 0) idle(int'($urandom_range(TIMEOUT - 3, TIMEOUT + 3)));
      else if (r < 3) step(1'b1, pool[$urandom_range(0, 11)], 1'b1);
      else if (r < 65) send(pool[$urandom_range(0, 11)]);
      else idle(1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
